add_cla_24: RTL and testbench
=============================

# add_cla_24

Registered 24-bit carry-lookahead adder: the datapath adder for the IEEE-754 single-precision mantissa path (24-bit significand including the hidden bit). It computes A + B + Cin with a two-level lookahead carry network and exports group generate/propagate, so larger adders can cascade it. Operands are sampled and results delivered on a single clock, with one cycle of latency.

## Interface
- No parameters; width is fixed at 24 (constant in shared package).
- iClk  input  1  rising-edge clock
- iRst  input  1  asynchronous, active-high reset
- iA  input  24  operand A, unsigned
- iB  input  24  operand B, unsigned
- iC  input  1  carry-in
- oS  output  24  sum bits [23:0], registered
- oG  output  1  group generate of the full 24-bit word, registered
- oP  output  1  group propagate of the full 24-bit word, registered
- oC  output  1  carry-out of bit 23, registered

## Operation
- Bitwise: g[i] = iA[i] & iB[i]; p[i] = iA[i] ^ iB[i].
- Six 4-bit groups (bits [3:0] … [23:20]), each with:
  - internal lookahead carries c[k+1] = g[k] | p[k]&c[k], flattened (no ripple);
  - group Gj and Pj outputs.
- Second-level lookahead over the six groups produces every group carry-in directly from iC, Gj and Pj (flattened sum-of-products, no ripple between groups).
- Sum: s[i] = p[i] ^ c[i], with c[0] = iC.
- Word outputs:
  - G = generate of all 24 bits, independent of iC;
  - P = &p[23:0];
  - carry-out = G | (P & iC).
- Arithmetic identity: {oC, oS} == iA + iB + iC as a 25-bit unsigned sum. No overflow flag; wrap is modulo 2^24 with oC as the 25th bit.
- oP and oG are never both 1.

## Timing
- Combinational lookahead is evaluated from the iA/iB/iC values present before the rising edge of iClk; the results are registered into oS/oG/oP/oC on that edge.
- Latency is 1 cycle; throughput is 1 addition per cycle; there is no handshake or enable.
- iRst high forces oS = 0, oG = 0, oP = 0, oC = 0 immediately, regardless of iClk.
- Outputs hold 0 while iRst is asserted.
- The first capture occurs on the first rising edge after iRst deasserts.
- Reset asserted while an addition is pending discards that result; nothing is queued.
- Inputs are unregistered; the critical path is input → lookahead → output flop.

## Structure
- Shared package `add_pkg`: ADD_W = 24, CLA_GRP = 4, NUM_GRP = 6.
- Sub-module `cla_4`:
  - inputs: a[3:0], b[3:0], cin;
  - outputs: s[3:0], g, p.
  - Instantiated 6 times.
- The top level contains:
  - the second-level 6-group carry lookahead;
  - word-level G/P/carry-out;
  - the output register bank.

## Test plan
- Reset: assert iRst mid-run with nonzero outputs → all outputs 0 immediately, no clock edge needed; they stay 0 until the first edge after release.
- iA=125, iB=11, iC=0 → next cycle oS=136, oC=0, oG=0, oP=0.
- iA=127, iB=105, iC=1 → oS=233, oC=0.
- iA=255, iB=255, iC=1 → oS=511, oC=0, oG=0, oP=0.
- iA=100, iB=215, iC=0 → oS=315, oC=0.
- Full-carry propagation, every group exercised:
  - iA=0xFFFFFF, iB=0, iC=1 → oS=0, oC=1, oP=1, oG=0;
  - iA=0xFFFFFF, iB=1, iC=0 → oS=0, oC=1, oG=1, oP=0;
  - back-to-back inputs on consecutive cycles each appear exactly one cycle later.
- Random regression: 10k random iA/iB/iC → {oC,oS} equals the 25-bit sum one cycle later.

Source files
------------

// File: rtl/add_pkg.sv
// add_pkg: shared widths and the group-level lookahead carry (OR of flattened generate/propagate products) for add_cla_24
package add_pkg;
    localparam int ADD_W   = 24;
    localparam int CLA_GRP = 4;
    localparam int NUM_GRP = 6;
    function automatic logic lookahead(
        input logic [NUM_GRP-1:0] g,
        input logic [NUM_GRP-1:0] p,
        input logic               cin,
        input int                 n
    );
        logic c;
        logic t;
        c = 1'b0;
        for (int k = -1; k < n; k++) begin
            t = (k < 0) ? cin : g[k];
            for (int m = k + 1; m < n; m++) t = t & p[m];
            c = c | t;
        end
        return c;
    endfunction
endpackage

// File: rtl/cla_4.sv
// cla_4: 4-bit lookahead slice; ports a, b, cin -> sum s, group generate g, group propagate p
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);
    logic [3:0] gb;
    logic [3:0] pb;
    logic [3:0] c;
    assign gb = a & b;
    assign pb = a ^ b;
    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & cin);
    assign s = pb ^ c;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign p = &pb;
endmodule

// File: rtl/add_cla_24.sv
// add_cla_24: registered 24-bit two-level CLA; iClk, iRst(async high), iA, iB, iC -> oS, oG, oP, oC one cycle later
module add_cla_24
    import add_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst,
    input  logic [ADD_W-1:0] iA,
    input  logic [ADD_W-1:0] iB,
    input  logic             iC,
    output logic [ADD_W-1:0] oS,
    output logic             oG,
    output logic             oP,
    output logic             oC
);
    logic [NUM_GRP-1:0] grp_g;
    logic [NUM_GRP-1:0] grp_p;
    logic [NUM_GRP-1:0] grp_c;
    logic [ADD_W-1:0]   sum;
    logic               word_g;
    logic               word_p;
    genvar j;
    generate
        for (j = 0; j < NUM_GRP; j++) begin : g_grp
            assign grp_c[j] = lookahead(grp_g, grp_p, iC, j);
            cla_4 u_cla (
                .a   (iA[j*CLA_GRP +: CLA_GRP]),
                .b   (iB[j*CLA_GRP +: CLA_GRP]),
                .cin (grp_c[j]),
                .s   (sum[j*CLA_GRP +: CLA_GRP]),
                .g   (grp_g[j]),
                .p   (grp_p[j])
            );
        end
    endgenerate
    assign word_g = lookahead(grp_g, grp_p, 1'b0, NUM_GRP);
    assign word_p = &grp_p;
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oS <= '0;
            oG <= 1'b0;
            oP <= 1'b0;
            oC <= 1'b0;
        end else begin
            oS <= sum;
            oG <= word_g;
            oP <= word_p;
            oC <= word_g | (word_p & iC);
        end
    end
endmodule

// File: tb/tb_add_cla_24.sv
// tb_add_cla_24: scoreboard bench for add_cla_24 against a 25-bit arithmetic reference
module tb_add_cla_24;
    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic [23:0] iA = '0;
    logic [23:0] iB = '0;
    logic        iC = 1'b0;
    logic [23:0] oS;
    logic        oG;
    logic        oP;
    logic        oC;
    logic [26:0] q[$];
    int          errors = 0;
    int          checks = 0;

    add_cla_24 dut (
        .iClk (iClk),
        .iRst (iRst),
        .iA   (iA),
        .iB   (iB),
        .iC   (iC),
        .oS   (oS),
        .oG   (oG),
        .oP   (oP),
        .oC   (oC)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string n, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {c,g,p,s}=%h expected %h", n, act, exp);
        end
    endtask

    // Expected word: {carry, generate, propagate, sum} from plain arithmetic.
    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic c);
        logic [24:0] total;
        logic [24:0] no_cin;
        @(negedge iClk);
        iA = a;
        iB = b;
        iC = c;
        total  = {1'b0, a} + {1'b0, b} + {24'd0, c};
        no_cin = {1'b0, a} + {1'b0, b};
        q.push_back({total[24], no_cin[24], (a ^ b) == 24'hFFFFFF, total[23:0]});
    endtask

    initial begin
        forever begin
            @(posedge iClk);
            #1;
            if (q.size() > 0) check("pipe", {oC, oG, oP, oS}, q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 iRst = 1'b1;
        #1 check("rst_init", {oC, oG, oP, oS}, 27'd0);
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        send(24'd125, 24'd11, 1'b0);
        send(24'd127, 24'd105, 1'b1);
        send(24'd255, 24'd255, 1'b1);
        send(24'd100, 24'd215, 1'b0);
        send(24'hFFFFFF, 24'd0, 1'b1);
        send(24'hFFFFFF, 24'd1, 1'b0);
        send(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        send(24'h800000, 24'h800000, 1'b0);
        send(24'h0F0F0F, 24'hF0F0F0, 1'b0);
        @(negedge iClk);
        iA = 24'h123456;
        iB = 24'd1;
        iC = 1'b0;
        @(posedge iClk);
        #3 check("pre_rst", {oC, oG, oP, oS}, {3'b000, 24'h123457});
        iRst = 1'b1;
        #1 check("rst_async", {oC, oG, oP, oS}, 27'd0);
        iA = 24'hFFFFFF;
        iB = 24'hFFFFFF;
        iC = 1'b1;
        @(posedge iClk);
        #1 check("rst_hold", {oC, oG, oP, oS}, 27'd0);
        @(negedge iClk);
        iRst = 1'b0;
        #1 check("rst_release", {oC, oG, oP, oS}, 27'd0);
        send(24'd125, 24'd11, 1'b0);
        for (int i = 0; i < 10000; i++)
            send(24'($urandom), 24'($urandom), 1'($urandom));
        repeat (2) @(negedge iClk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never appeared, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
